// File: rtl/stallable_pipeline_addsub.sv
// Parametrised stallable add/subtract pipeline, one operand slice per stage.
// Valid/allow handshake at both ends with per-stage pause and refresh.
module stallable_pipeline_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              in_allow,
    input  logic              sub,
    input  logic              c_in,
    input  logic [WIDTH-1:0]  data_a,
    input  logic [WIDTH-1:0]  data_b,
    input  logic [STAGES-1:0] pause,
    input  logic [STAGES-1:0] refresh,
    input  logic              out_allow,
    output logic              valid_out,
    output logic [WIDTH-1:0]  sum_out,
    output logic              c_out,
    output logic              ovf_out
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]             valid_q;
    logic [STAGES-2:0][WIDTH-1:0]  a_q;
    logic [STAGES-2:0][WIDTH-1:0]  b_q;
    logic [STAGES-1:0][WIDTH-1:0]  sum_q;
    logic [STAGES-1:0]             cy_q;
    logic [STAGES-1:0]             sub_q;
    logic                          ovf_q;

    logic [STAGES:0]               allow;
    logic [STAGES-1:0]             load;
    logic [STAGES-1:0]             go;

    logic [STAGES-1:0][WIDTH-1:0]  a_d;
    logic [STAGES-1:0][WIDTH-1:0]  b_d;
    logic [STAGES-1:0][WIDTH-1:0]  s_d;
    logic [STAGES-1:0][WIDTH-1:0]  s_n;
    logic [STAGES-1:0]             c_d;
    logic [STAGES-1:0]             c_n;
    logic [STAGES-1:0]             sub_d;
    logic                          ovf_n;

    assign go = ~pause;

    // Allow chain runs from the output back to the input; loads follow it.
    always_comb begin
        allow         = '0;
        load          = '0;
        allow[STAGES] = out_allow;
        for (int k = STAGES - 1; k >= 0; k--) begin
            allow[k] = ~refresh[k] & (~valid_q[k] | (go[k] & allow[k+1]));
        end
        load[0] = valid_in & allow[0];
        for (int k = 1; k < STAGES; k++) begin
            load[k] = valid_q[k-1] & go[k-1] & allow[k];
        end
    end

    // Stage operands: stage 0 from the ports, later stages from upstream.
    always_comb begin
        a_d      = '0;
        b_d      = '0;
        s_d      = '0;
        c_d      = '0;
        sub_d    = '0;
        a_d[0]   = data_a;
        b_d[0]   = sub ? ~data_b : data_b;
        c_d[0]   = sub ? ~c_in : c_in;
        sub_d[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            s_d[k]   = sum_q[k-1];
            c_d[k]   = cy_q[k-1];
            sub_d[k] = sub_q[k-1];
        end
    end

    // Each stage adds its own slice and patches it into the partial sum.
    always_comb begin
        logic [SW:0] sl;
        s_n = '0;
        c_n = '0;
        sl  = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl = {1'b0, a_d[k][k*SW +: SW]}
               + {1'b0, b_d[k][k*SW +: SW]}
               + {{SW{1'b0}}, c_d[k]};
            s_n[k]              = s_d[k];
            s_n[k][k*SW +: SW]  = sl[SW-1:0];
            c_n[k]              = sl[SW];
        end
        ovf_n = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1])
              & (s_n[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    end

    // Stage valid bits and data registers; rst beats pause and refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cy_q    <= '0;
            sub_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (refresh[k]) begin
                    valid_q[k] <= 1'b0;
                end else if (load[k]) begin
                    valid_q[k] <= 1'b1;
                end else if (go[k] & allow[k+1]) begin
                    valid_q[k] <= 1'b0;
                end
                if (load[k]) begin
                    sum_q[k] <= s_n[k];
                    cy_q[k]  <= c_n[k];
                    sub_q[k] <= sub_d[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (load[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                end
            end
            if (load[LAST]) begin
                ovf_q <= ovf_n;
            end
        end
    end

    assign in_allow  = allow[0];
    assign valid_out = valid_q[LAST];
    assign sum_out   = sum_q[LAST];
    assign c_out     = cy_q[LAST];
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_stallable_pipeline_addsub.sv
// Directed bench for stallable_pipeline_addsub (32/4 and 64/8 builds).
// Output items are checked in order against a queue of hand-computed results.
module tb_stallable_pipeline_addsub;
    localparam int W  = 32;
    localparam int S  = 4;
    localparam int W8 = 64;
    localparam int S8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid_in, sub, c_in, out_allow;
    logic [W-1:0]  data_a, data_b;
    logic [S-1:0]  pause, refresh;
    logic          in_allow, valid_out, c_out, ovf_out;
    logic [W-1:0]  sum_out;

    logic          rst8, valid_in8, sub8, c_in8, out_allow8;
    logic [W8-1:0] data_a8, data_b8;
    logic [S8-1:0] pause8, refresh8;
    logic          in_allow8, valid_out8, c_out8, ovf_out8;
    logic [W8-1:0] sum_out8;

    stallable_pipeline_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_allow(in_allow),
        .sub(sub), .c_in(c_in), .data_a(data_a), .data_b(data_b),
        .pause(pause), .refresh(refresh), .out_allow(out_allow),
        .valid_out(valid_out), .sum_out(sum_out), .c_out(c_out),
        .ovf_out(ovf_out)
    );

    stallable_pipeline_addsub #(.WIDTH(W8), .STAGES(S8)) dut8 (
        .clk(clk), .rst(rst8), .valid_in(valid_in8), .in_allow(in_allow8),
        .sub(sub8), .c_in(c_in8), .data_a(data_a8), .data_b(data_b8),
        .pause(pause8), .refresh(refresh8), .out_allow(out_allow8),
        .valid_out(valid_out8), .sum_out(sum_out8), .c_out(c_out8),
        .ovf_out(ovf_out8)
    );

    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one item and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci,
                        input logic [33:0] e);
        valid_in = 1'b1;
        data_a   = a;
        data_b   = b;
        sub      = s;
        c_in     = ci;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_allow) begin
                exp_q.push_back(e);
                cyc();
                valid_in = 1'b0;
                return;
            end
            cyc();
        end
        check("send_timeout", in_allow, 1);
        valid_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        valid_in = 1'b0;
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) cyc();
        check(tag, exp_q.size(), 0);
    endtask

    // Every result transfer must match the next expected item.
    always @(negedge clk) begin
        if (!rst && valid_out && out_allow) begin
            check("out_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
                check("out_item", {ovf_out, c_out, sum_out}, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    int idx;

    initial begin
        rst = 1'b1; valid_in = 1'b0; sub = 1'b0; c_in = 1'b0;
        out_allow = 1'b1; data_a = '0; data_b = '0;
        pause = '0; refresh = '0;
        rst8 = 1'b1; valid_in8 = 1'b0; sub8 = 1'b0; c_in8 = 1'b0;
        out_allow8 = 1'b1; data_a8 = '0; data_b8 = '0;
        pause8 = '0; refresh8 = '0;
        cyc();
        cyc();
        check("rst_valid_out", valid_out, 0);
        check("rst_sum_out", sum_out, 0);
        check("rst_c_out", c_out, 0);
        check("rst_ovf_out", ovf_out, 0);
        check("rst_in_allow", in_allow, 1);
        rst  = 1'b0;
        rst8 = 1'b0;

        // 1: back-to-back 18+13, first result after 4 edges
        for (int i = 0; i < 8; i++) begin
            send(32'd18, 32'd13, 1'b0, 1'b0, {2'b00, 32'd31});
            check("t1_latency", valid_out, (i >= 3));
        end
        drain("t1_drain");

        // 2: subtract, carry and overflow corners
        send(32'd5, 32'd7, 1'b1, 1'b0, {2'b00, 32'hFFFF_FFFE});
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, {2'b01, 32'h7FFF_FFFE});
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {2'b10, 32'h8000_0000});
        send(32'd10, 32'd3, 1'b1, 1'b1, {2'b01, 32'd6});
        send(32'h8000_0000, 32'd1, 1'b1, 1'b0, {2'b11, 32'h7FFF_FFFF});
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, {2'b01, 32'd1});
        drain("t2_drain");

        // 3: stream A=i, B=2i with pause[1] for two cycles
        idx = 1;
        for (int n = 0; n < 16; n++) begin
            pause    = (n == 6 || n == 7) ? 4'b0010 : 4'b0000;
            valid_in = 1'b1;
            data_a   = idx;
            data_b   = 2 * idx;
            sub      = 1'b0;
            c_in     = 1'b0;
            @(negedge clk);
            if (n == 6 || n == 7) check("t3_in_allow_paused", in_allow, 0);
            if (in_allow) begin
                exp_q.push_back({2'b00, 32'(3 * idx)});
                idx++;
            end
            cyc();
        end
        pause = '0;
        check("t3_accepted", idx - 1, 14);
        drain("t3_drain");

        // 4: refresh stage 2 while the full pipe is blocked at the output
        out_allow = 1'b0;
        for (int j = 1; j <= 4; j++)
            send(32'(100 + j), 32'd0, 1'b0, 1'b0, {2'b00, 32'(100 + j)});
        exp_q.delete(1);
        refresh = 4'b0100;
        @(negedge clk);
        check("t4_in_allow_refresh", in_allow, 0);
        cyc();
        refresh = '0;
        check("t4_head_valid", valid_out, 1);
        check("t4_head_sum", sum_out, 101);
        out_allow = 1'b1;
        drain("t4_drain");

        // 5: out_allow low for 5 cycles with the pipe full
        out_allow = 1'b0;
        for (int j = 0; j < 4; j++)
            send(32'(200 + j), 32'd0, 1'b0, 1'b0, {2'b00, 32'(200 + j)});
        valid_in = 1'b1;
        data_a   = 32'd204;
        data_b   = 32'd0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("t5_in_allow", in_allow, 0);
            check("t5_valid_out", valid_out, 1);
            check("t5_sum_hold", sum_out, 200);
            cyc();
        end
        out_allow = 1'b1;
        send(32'd204, 32'd0, 1'b0, 1'b0, {2'b00, 32'd204});
        drain("t5_drain");

        // 6: reset mid-stream while stage 0 is paused
        for (int j = 0; j < 6; j++)
            send(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0,
                 {2'b11, 32'h7FFF_FFFF});
        rst      = 1'b1;
        pause    = 4'b0001;
        valid_in = 1'b1;
        exp_q.delete();
        cyc();
        rst      = 1'b0;
        valid_in = 1'b0;
        check("t6_valid_out", valid_out, 0);
        check("t6_sum_out", sum_out, 0);
        check("t6_c_out", c_out, 0);
        check("t6_ovf_out", ovf_out, 0);
        check("t6_in_allow_paused_empty", in_allow, 1);
        cyc();
        pause = '0;
        @(negedge clk);
        check("t6_in_allow", in_allow, 1);
        cyc();
        send(32'd18, 32'd13, 1'b0, 1'b0, {2'b00, 32'd31});
        drain("t6_drain");

        // 64-bit, 8-stage build: one item, 8 edges to the output
        valid_in8 = 1'b1;
        data_a8   = 64'd18;
        data_b8   = 64'd13;
        @(negedge clk);
        check("w64_in_allow", in_allow8, 1);
        cyc();
        valid_in8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check("w64_latency", valid_out8, (k == 8));
            if (k == 8) begin
                check("w64_sum", sum_out8, 31);
                check("w64_c_out", c_out8, 0);
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stallable_pipeline_addsub.md
Name: stallable_pipeline_addsub

Overview:
- Parametrised successor to the team's 4-stage stallable pipeline adder.
- Configurable operand width and stage count; adds a subtract mode and signed-overflow flag.
- Full valid/allow handshake on both ends, so the block can sit between handshaked producers and consumers in the datapath.
- Per-stage pause (hold) and refresh (flush) controls; stage k computes slice k of the operands, carry ripples stage to stage.

Parameters:
WIDTH  32  operand/result width in bits; must be a multiple of STAGES
STAGES  4  pipeline depth (>=2); slice width SW = WIDTH/STAGES

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1  input operands valid
in_allow  output  1  block can accept an input this cycle
sub  input  1  0: add, 1: subtract
c_in  input  1  carry-in (add) / borrow-in (sub)
data_a  input  WIDTH  operand A
data_b  input  WIDTH  operand B
pause  input  STAGES  pause[k]=1 holds stage k
refresh  input  STAGES  refresh[k]=1 flushes stage k
out_allow  input  1  downstream accepts result
valid_out  output  1  result valid
sum_out  output  WIDTH  result
c_out  output  1  final carry-out (sub: 1 = no borrow)
ovf_out  output  1  signed overflow of result

Behaviour:
- Reset: all stage valid bits = 0; all stage data/carry registers = 0; valid_out=0, sum_out=0, c_out=0, ovf_out=0. Reset mid-operation discards all in-flight items; rst overrides pause/refresh.
- Arithmetic: effective B = sub ? ~data_b : data_b; effective carry-in = sub ? ~c_in : c_in. Result = A + B_eff + cin_eff mod 2^WIDTH, i.e. sub gives A - B - c_in. ovf_out = (A[MSB]==B_eff[MSB]) && (sum[MSB]!=A[MSB]).
- Stage k (0..STAGES-1) adds slice k (bits k*SW+SW-1 : k*SW) with carry from stage k-1 (stage 0 uses cin_eff). It carries forward the unused higher slices of A and B_eff and the already-computed lower sum slices; the item's sub value is carried with it.
- Handshake per stage:
  - ready_go_k = ~pause[k]
  - allow_k = ~refresh[k] & (~valid_k | (ready_go_k & allow_{k+1}))
  - allow_STAGES = out_allow
  - in_allow = allow_0
- Stage 0 loads when valid_in & allow_0. Stage k>0 loads when valid_{k-1} & ready_go_{k-1} & allow_k.
- valid_k next value:
  - 0 if refresh[k]
  - else 1 if loading
  - else 0 if (ready_go_k & allow_{k+1})
  - else hold.
- Refresh: refresh[k] empties stage k at the edge and blocks stage k-1 from advancing that cycle. The stage k-1 item is held, not lost. Multiple refresh bits act independently.
- Pause: pause[k] holds stage k data and valid and backpressures upstream. An empty paused stage still accepts an item (it is not ready to go, but has room).
- Output: valid_out = valid_{STAGES-1}. sum_out/c_out/ovf_out come from the last stage registers and are stable while valid_out & ~out_allow.
- Latency: STAGES cycles from acceptance to valid_out with no stalls. Throughput: 1 item/cycle.
- Order is preserved; no item is duplicated or dropped except by refresh or rst.

Test Plan:
1. WIDTH=32, STAGES=4; A=18, B=13, c_in=0, sub=0, valid_in held 1, out_allow=1 -> first valid_out 4 cycles after acceptance, sum_out=31, c_out=0, ovf_out=0; valid_out stays 1 every cycle.
2. sub=1, A=5, B=7, c_in=0 -> sum_out=0xFFFFFFFE, c_out=0. Then A=0x7FFFFFFF, B=0xFFFFFFFF, sub=0 -> sum_out=0x7FFFFFFE, c_out=1, ovf_out=0. Then A=0x7FFFFFFF, B=1 -> sum_out=0x80000000, ovf_out=1.
3. Streaming distinct A=i, B=2i; pause[1]=1 for 2 cycles -> in_allow=0 once stages 0..1 are full; no item lost or duplicated; output sequence 3i unchanged with a 2-cycle bubble.
4. refresh[2]=1 for 1 cycle with the stage full -> that single item never appears at output; the preceding and following items appear in order; the stage 1 item is held one cycle.
5. out_allow=0 for 5 cycles with the pipeline full -> valid_out=1 and sum_out constant throughout; in_allow=0 after the pipe fills; resumes in order when out_allow=1.
6. rst=1 for 1 cycle mid-stream with pause[0]=1 -> next cycle valid_out=0, sum_out=0, c_out=0, ovf_out=0, in_allow=1 once pause drops; STAGES=8, WIDTH=64 variant of scenario 1 gives sum 31 after 8 cycles.
